// File: rtl/i2q2_calculator_pkg.sv
// Shared types and constants for the I^2+Q^2 calculator.
// Holds the FSM state encoding and the operand/sequence constants.
package i2q2_calculator_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int N_OPS         = 6;

    // sel value on the drain edge: last product is summed here.
    localparam logic [2:0] SEL_DRAIN = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/i2q2_calculator_square_pipe.sv
// Registered signed squarer, one cycle latency.
// Ports: clk, global_reset, a (signed ACC_WIDTH), sq (unsigned I2Q2_WIDTH).
module i2q2_calculator_square_pipe #(
    parameter int ACC_WIDTH  = 16,
    parameter int I2Q2_WIDTH = 2 * ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         global_reset,
    input  logic signed [ACC_WIDTH-1:0]  a,
    output logic        [I2Q2_WIDTH-1:0] sq
);

    logic signed [I2Q2_WIDTH-1:0] a_ext;

    // A square is never negative and fits in I2Q2_WIDTH, so the
    // low half of the extended product is the exact result.
    assign a_ext = I2Q2_WIDTH'(a);

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            sq <= '0;
        end else begin
            sq <= I2Q2_WIDTH'(a_ext * a_ext);
        end
    end

endmodule

// File: rtl/i2q2_calculator.sv
// Computes I^2+Q^2 for early/prompt/late taps using one shared squarer.
// Ports: clk, global_reset, accumulation_complete, six signed I/Q inputs;
// outputs i2q2_early/prompt/late (held), i2q2_valid, busy, overrun.
module i2q2_calculator
    import i2q2_calculator_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int I2Q2_WIDTH = 2 * ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         global_reset,
    input  logic                         accumulation_complete,
    input  logic signed [ACC_WIDTH-1:0]  i_early,
    input  logic signed [ACC_WIDTH-1:0]  q_early,
    input  logic signed [ACC_WIDTH-1:0]  i_prompt,
    input  logic signed [ACC_WIDTH-1:0]  q_prompt,
    input  logic signed [ACC_WIDTH-1:0]  i_late,
    input  logic signed [ACC_WIDTH-1:0]  q_late,
    output logic        [I2Q2_WIDTH-1:0] i2q2_early,
    output logic        [I2Q2_WIDTH-1:0] i2q2_prompt,
    output logic        [I2Q2_WIDTH-1:0] i2q2_late,
    output logic                         i2q2_valid,
    output logic                         busy,
    output logic                         overrun
);

    state_t                       state, next_state;
    logic [2:0]                   sel;
    logic signed [ACC_WIDTH-1:0]  op [N_OPS];
    logic signed [ACC_WIDTH-1:0]  op_sel;
    logic [I2Q2_WIDTH-1:0]        prod;
    logic [I2Q2_WIDTH-1:0]        partial;
    logic [I2Q2_WIDTH-1:0]        sh_early, sh_prompt, sh_late;

    always_comb begin
        op_sel = '0;
        case (sel)
            3'd0:    op_sel = op[0];
            3'd1:    op_sel = op[1];
            3'd2:    op_sel = op[2];
            3'd3:    op_sel = op[3];
            3'd4:    op_sel = op[4];
            3'd5:    op_sel = op[5];
            default: op_sel = '0;
        endcase
    end

    i2q2_calculator_square_pipe #(
        .ACC_WIDTH  (ACC_WIDTH),
        .I2Q2_WIDTH (I2Q2_WIDTH)
    ) u_square (
        .clk          (clk),
        .global_reset (global_reset),
        .a            (op_sel),
        .sq           (prod)
    );

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A strobe restarts the sequence from any state.
    always_comb begin
        next_state = state;
        if (accumulation_complete) begin
            next_state = SQUARE;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                SQUARE:  if (sel == SEL_DRAIN) next_state = COMMIT;
                COMMIT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            sel         <= '0;
            for (int k = 0; k < N_OPS; k++) op[k] <= '0;
            partial     <= '0;
            sh_early    <= '0;
            sh_prompt   <= '0;
            sh_late     <= '0;
            i2q2_early  <= '0;
            i2q2_prompt <= '0;
            i2q2_late   <= '0;
            i2q2_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            i2q2_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= (next_state != IDLE);
            if (accumulation_complete) begin
                op[0]   <= i_early;
                op[1]   <= q_early;
                op[2]   <= i_prompt;
                op[3]   <= q_prompt;
                op[4]   <= i_late;
                op[5]   <= q_late;
                sel     <= '0;
                overrun <= (state != IDLE);
            end else if (state == SQUARE) begin
                sel <= sel + 3'd1;
                // prod holds the square of operand sel-1.
                case (sel)
                    3'd1, 3'd3, 3'd5: partial   <= prod;
                    3'd2:             sh_early  <= partial + prod;
                    3'd4:             sh_prompt <= partial + prod;
                    3'd6:             sh_late   <= partial + prod;
                    default: ;
                endcase
            end else if (state == COMMIT) begin
                i2q2_early  <= sh_early;
                i2q2_prompt <= sh_prompt;
                i2q2_late   <= sh_late;
                i2q2_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/i2q2_calculator.md
Name: i2q2_calculator

Overview:
- Sits directly upstream of the acquisition controller and the tracking loops.
- Takes the signed early/prompt/late I and Q correlator accumulations, latched when accumulation_complete pulses, and computes I^2+Q^2 for each tap.
- Uses one shared, registered squaring multiplier that is time-multiplexed over six operands.
- Presents the three unsigned results together, held stable, with a one-cycle i2q2_valid pulse. The peak search consumes them over several cycles, so they must not change under it.

Parameters:
- ACC_WIDTH, 16: width of each signed I/Q accumulation.
- I2Q2_WIDTH, 2*ACC_WIDTH (32): width of each unsigned I2Q2 result; must equal 2*ACC_WIDTH.

Ports:
- clk  in  1  system clock.
- global_reset  in  1  asynchronous, active-high reset.
- accumulation_complete  in  1  one-cycle strobe; all six accumulation inputs are valid in that cycle.
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  in  ACC_WIDTH each  signed accumulations.
- i2q2_early, i2q2_prompt, i2q2_late  out  I2Q2_WIDTH each  unsigned I^2+Q^2 per tap.
- i2q2_valid  out  1  one-cycle pulse; the three results are newly updated.
- busy  out  1  a computation is in progress.
- overrun  out  1  one-cycle pulse; a computation was aborted by a new strobe.

Behaviour:
- Reset, asynchronous, active-high: all outputs 0, FSM in IDLE, operand/shadow/partial registers 0. Reset mid-computation discards it; no i2q2_valid follows.
- Timing reference: E0 is the clk edge that samples accumulation_complete=1; En is the n-th edge after E0.
- E0 actions:
  - capture all six inputs into operand registers;
  - set sel=0;
  - enter SQUARE;
  - set busy=1 (registered, so visible after E0).
- Multiplier: prod <= op[sel]*op[sel], signed x signed. Operand order for sel 0..5: i_e, q_e, i_p, q_p, i_l, q_l.
  - Product for sel k is registered at E(k+1).
  - sel increments each edge while in SQUARE.
- Summation:
  - At E(k+2) for even k: partial <= prod.
  - At E(k+2) for odd k: shadow[tap] <= partial + prod, with taps early/prompt/late at E3/E5/E7.
  - FSM moves SQUARE -> COMMIT at E7.
- COMMIT, at E8:
  - i2q2_early/prompt/late <= shadows, atomically;
  - i2q2_valid=1 for exactly one cycle;
  - busy=0;
  - FSM -> IDLE.
- Fixed latency: 8 clocks from the strobe-sampling edge to the edge that asserts valid.
- Output hold: outputs hold their values until the next COMMIT or reset. No partial update is ever visible on the outputs.
- Width: each square is at most 2^(2*ACC_WIDTH-2), since (-2^(ACC_WIDTH-1))^2 is the largest. The sum of two squares is at most 2^(2*ACC_WIDTH-1), so it fits in I2Q2_WIDTH unsigned bits. No saturation or truncation.
- Strobe while busy (SQUARE or COMMIT): the in-flight computation is aborted.
  - overrun pulses one cycle (visible after that edge).
  - New operands are captured and the sequence restarts from sel=0 per E0 rules.
  - No valid is produced for the aborted set.
  - A strobe on the COMMIT edge (E8) aborts too: outputs are not updated and valid does not assert.
- Strobes back-to-back every 9+ cycles yield one valid per strobe.
- FSM states: IDLE, SQUARE (6 cycles, sel 0..5, plus the drain edge E7), COMMIT. Strobe from any state goes to SQUARE.

Decomposition:
- Shared header (existing global/channel .vh): `ACC_WIDTH / `ACC_RANGE, `I2Q2_WIDTH / `I2Q2_RANGE, and the FSM state encodings. The I2Q2 macros are the same definitions the acquisition controller uses.
- One natural sub-module: square_pipe, a registered signed squarer (ACC_WIDTH in, I2Q2_WIDTH out, 1-cycle latency). It allows a DSP-block inference swap later.

Test Plan:
- Single strobe with i_e=3, q_e=4, i_p=-5, q_p=12, i_l=0, q_l=0 -> exactly 8 edges later, i2q2_valid pulses once with early=25, prompt=169, late=0. busy is high for cycles 1..8.
- Extremes with ACC_WIDTH=16: all six inputs = -32768 -> each output = 2147483648 (0x80000000). Then all = 32767 -> each output = 2147352578.
- Output hold check: after one valid, change inputs without a strobe for 50 cycles -> outputs unchanged and no valid.
- Abort: second strobe 4 cycles after the first, carrying i_e=1, other operands 0 -> overrun pulses once. A single valid follows 8 edges after the second strobe with early=1, prompt=0, late=0. No valid for the first set.
- Asynchronous reset asserted mid-SQUARE (cycle 5) -> outputs go to 0 immediately and busy=0. No valid follows. The next strobe then computes correctly.
- Back-to-back strobes every 9 cycles for 10 iterations with random operands -> 10 valid pulses, each matching the reference model I^2+Q^2 per tap.
